// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_pkg
//  Description : Shared types, defaults and sizing helpers for the
//                8-to-1 mux channel scanner.
//  Revision    : 1.0  initial release
// ============================================================================
package mux_scan_pkg;

  // Default select width; the scanned mux has 2**SEL_W inputs.
  localparam int SEL_W_DEF = 3;

  // Default number of clocks sel is held before mux_y is sampled.
  localparam int DWELL_DEF = 2;

  // State encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SCAN = ST_SCAN,
    DONE = ST_DONE
  } state_t;

  // Channel count for a given select width.
  function automatic int n_ch_of(input int sel_w);
    return 1 << sel_w;
  endfunction

  // Dwell counter width: it only has to count 0..dwell-1, but never
  // narrower than one bit so DWELL=1 still has a legal vector.
  function automatic int dwell_cnt_w(input int dwell);
    if (dwell <= 2) return 1;
    return $clog2(dwell);
  endfunction

endpackage : mux_scan_pkg
`default_nettype wire

// File: rtl/mux_channel_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_channel_scanner_if
//  Description : Control, mux-side and downstream handshake signals of the
//                channel scanner. The slave modport is the scanner's view,
//                the master modport is the controlling environment's view.
//  Revision    : 1.0  initial release
// ============================================================================
interface mux_channel_scanner_if #(
  parameter int SEL_W = mux_scan_pkg::SEL_W_DEF
);
  localparam int N_CH = mux_scan_pkg::n_ch_of(SEL_W);

  logic             start;
  logic [N_CH-1:0]  ch_mask;
  logic             busy;
  logic [SEL_W-1:0] sel;
  logic             mux_y;
  logic [N_CH-1:0]  data;
  logic             data_valid;
  logic             data_ready;

  modport slave (
    input  start,
    input  ch_mask,
    input  mux_y,
    input  data_ready,
    output busy,
    output sel,
    output data,
    output data_valid
  );

  modport master (
    output start,
    output ch_mask,
    output mux_y,
    output data_ready,
    input  busy,
    input  sel,
    input  data,
    input  data_valid
  );

endinterface : mux_channel_scanner_if
`default_nettype wire

// File: rtl/mux_scan_next_ch.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_next_ch
//  Description : Combinational priority search for the lowest enabled
//                channel at or above (include_cur=1) or strictly above
//                (include_cur=0) cur_sel.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_scan_next_ch
  import mux_scan_pkg::*;
#(
  parameter  int SEL_W = SEL_W_DEF,
  localparam int N_CH  = n_ch_of(SEL_W)
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] cur_sel,
  input  logic             include_cur,
  output logic [SEL_W-1:0] next_sel,
  output logic             found
);

  logic [N_CH-1:0] cand;

  // A channel is a candidate if enabled and in the allowed range.
  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_cand
      assign cand[i] = mask[i] &
                       ((SEL_W'(i) > cur_sel) |
                        (include_cur & (SEL_W'(i) == cur_sel)));
    end
  endgenerate

  // Scan from the top down so the lowest candidate is the last one written.
  always_comb begin
    next_sel = '0;
    found    = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        next_sel = SEL_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule : mux_scan_next_ch
`default_nettype wire

// File: rtl/mux_channel_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : mux_channel_scanner
//  Description : Steps the select lines of an external 8-to-1 mux through
//                the enabled channels, samples mux_y after DWELL clocks per
//                channel and returns the assembled word over valid/ready.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_channel_scanner
  import mux_scan_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  mux_channel_scanner_if.slave   bus
);

  localparam int               N_CH     = n_ch_of(SEL_W);
  localparam int               CNT_W    = dwell_cnt_w(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic [N_CH-1:0]   shadow_q, shadow_d;
  logic [N_CH-1:0]   data_q, data_d;
  logic              valid_q, valid_d;

  logic [SEL_W-1:0]  first_sel;
  logic              first_found;
  logic [SEL_W-1:0]  next_sel;
  logic              next_found;

  // First channel of a new scan comes straight from the live mask.
  mux_scan_next_ch #(.SEL_W(SEL_W)) u_first_ch (
    .mask        (bus.ch_mask),
    .cur_sel     ('0),
    .include_cur (1'b1),
    .next_sel    (first_sel),
    .found       (first_found)
  );

  // Next channel within a scan uses the latched mask, strictly ascending.
  mux_scan_next_ch #(.SEL_W(SEL_W)) u_next_ch (
    .mask        (mask_q),
    .cur_sel     (sel_q),
    .include_cur (1'b0),
    .next_sel    (next_sel),
    .found       (next_found)
  );

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (!first_found) begin
            // Nothing enabled: report an all-zero word immediately.
            data_d  = '0;
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            mask_d   = bus.ch_mask;
            sel_d    = first_sel;
            cnt_d    = '0;
            shadow_d = '0;
            state_d  = SCAN;
          end
        end
      end

      SCAN: begin
        if (cnt_q == CNT_LAST) begin
          shadow_d[sel_q] = bus.mux_y;
          if (next_found) begin
            sel_d = next_sel;
            cnt_d = '0;
          end else begin
            // Last channel: publish including the bit sampled this edge.
            data_d  = shadow_d;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (valid_q && bus.data_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = (state_q != IDLE);

endmodule : mux_channel_scanner
`default_nettype wire

// File: tb/tb_mux_channel_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_channel_scanner
//  Description : Self-checking bench for mux_channel_scanner. Two scanners
//                (DWELL=1 and DWELL=2) each drive their own model of the
//                8-to-1 mux from a shared input pattern.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux_channel_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start2, ready;
  logic [7:0] mask, mux_in;
  logic       dsel;

  int checks = 0;
  int errors = 0;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  mux_channel_scanner_if #(.SEL_W(3)) b1 ();
  mux_channel_scanner_if #(.SEL_W(3)) b2 ();

  assign b1.start      = start1;
  assign b1.ch_mask    = mask;
  assign b1.data_ready = ready;
  assign b1.mux_y      = mux_in[b1.sel];

  assign b2.start      = start2;
  assign b2.ch_mask    = mask;
  assign b2.data_ready = ready;
  assign b2.mux_y      = mux_in[b2.sel];

  mux_channel_scanner #(.SEL_W(3), .DWELL(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  mux_channel_scanner #(.SEL_W(3), .DWELL(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  // Outputs of whichever scanner the current test is exercising.
  logic [2:0] c_sel;
  logic [7:0] c_data;
  logic       c_valid, c_busy;
  assign c_sel   = dsel ? b2.sel        : b1.sel;
  assign c_data  = dsel ? b2.data       : b1.data;
  assign c_valid = dsel ? b2.data_valid : b1.data_valid;
  assign c_busy  = dsel ? b2.busy       : b1.busy;

  typedef struct {
    bit         dut;
    logic [7:0] pins;
    logic [7:0] msk;
    logic [7:0] exp_data;
    int         exp_edges;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit which);
    if (which) start2 = 1'b1; else start1 = 1'b1;
    step();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Counts edges after E0 until valid, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!c_valid && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic handshake();
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_sel2[6];
    bit seen;

    vecs[0] = '{1'b0, 8'hA5, 8'hFF, 8'hA5, 8};
    vecs[1] = '{1'b1, 8'hFF, 8'h85, 8'h85, 6};
    vecs[2] = '{1'b0, 8'h3C, 8'h00, 8'h00, 0};
    vecs[3] = '{1'b1, 8'h5A, 8'hF0, 8'h50, 8};
    vecs[4] = '{1'b0, 8'hC3, 8'h81, 8'h81, 2};
    vecs[5] = '{1'b1, 8'h0F, 8'h18, 8'h08, 4};
    vecs[6] = '{1'b0, 8'h96, 8'h7E, 8'h16, 6};
    exp_sel2 = '{0, 0, 2, 2, 7, 7};

    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; ready = 1'b0;
    mask = 8'h00; mux_in = 8'h00; dsel = 1'b0;

    // Reset state.
    step();
    step();
    chk("rst sel", b1.sel, 0);
    chk("rst busy", b1.busy, 0);
    chk("rst valid", b1.data_valid, 0);
    chk("rst data", b1.data, 0);
    chk("rst valid d2", b2.data_valid, 0);
    rst = 1'b0;
    step();

    // Full scan, DWELL=1: sel ascends one channel per clock.
    dsel = 1'b0; mux_in = 8'hA5; mask = 8'hFF;
    pulse_start(1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("t2 sel step", c_sel, i);
      if (i == 7) chk("t2 valid early", c_valid, 0);
      step();
    end
    chk("t2 valid", c_valid, 1);
    chk("t2 data", c_data, 8'hA5);
    chk("t2 sel hold", c_sel, 7);
    handshake();
    chk("t2 busy after hs", c_busy, 0);

    // Sparse mask, DWELL=2: visits only 0, 2, 7 for two clocks each.
    dsel = 1'b1; mux_in = 8'hFF; mask = 8'h85;
    pulse_start(1'b1);
    for (int i = 0; i < 6; i++) begin
      chk("t3 sel", c_sel, exp_sel2[i]);
      chk("t3 valid early", c_valid, 0);
      step();
    end
    chk("t3 valid", c_valid, 1);
    chk("t3 data", c_data, 8'h85);
    handshake();

    // Table of scans on both dwell settings.
    for (int v = 0; v < 7; v++) begin
      dsel = vecs[v].dut; mux_in = vecs[v].pins; mask = vecs[v].msk;
      pulse_start(vecs[v].dut);
      wait_valid(n);
      chk($sformatf("vec%0d edges", v), n, vecs[v].exp_edges);
      chk($sformatf("vec%0d data", v), c_data, vecs[v].exp_data);
      chk($sformatf("vec%0d busy", v), c_busy, 1);
      handshake();
      chk($sformatf("vec%0d busy after hs", v), c_busy, 0);
      chk($sformatf("vec%0d valid after hs", v), c_valid, 0);
      chk($sformatf("vec%0d data held", v), c_data, vecs[v].exp_data);
    end

    // Backpressure: start pulses while DONE are ignored, data holds.
    dsel = 1'b0; mux_in = 8'h3C; mask = 8'h66;
    pulse_start(1'b0);
    wait_valid(n);
    chk("t5 edges", n, 4);
    for (int i = 0; i < 5; i++) begin
      start1 = 1'b1;
      mux_in = 8'hFF;
      step();
      chk("t5 data hold", c_data, 8'h24);
      chk("t5 valid hold", c_valid, 1);
      chk("t5 busy hold", c_busy, 1);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    start1 = 1'b0;
    chk("t5 busy after hs", c_busy, 0);
    chk("t5 valid after hs", c_valid, 0);
    step();
    chk("t5 start not queued", c_busy, 0);

    // Asynchronous reset while idle, no clock edge needed.
    #2 rst = 1'b1;
    #1;
    chk("t1 sel", c_sel, 0);
    chk("t1 busy", c_busy, 0);
    chk("t1 valid", c_valid, 0);
    chk("t1 data", c_data, 0);
    #2 rst = 1'b0;
    step();

    // Reset mid-scan aborts it; a later scan works normally.
    mux_in = 8'h0F; mask = 8'hFF;
    pulse_start(1'b0);
    step(); step(); step();
    chk("t6 sel before rst", c_sel, 3);
    #2 rst = 1'b1;
    #1;
    chk("t6 sel async", c_sel, 0);
    chk("t6 busy async", c_busy, 0);
    chk("t6 valid async", c_valid, 0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (c_valid) seen = 1'b1;
    end
    chk("t6 no valid after abort", seen, 0);
    pulse_start(1'b0);
    wait_valid(n);
    chk("t6 edges", n, 8);
    chk("t6 data", c_data, 8'h0F);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_channel_scanner
`default_nettype wire
